dm_access_ctrl: RTL
===================

# dm_access_ctrl

Sequencing controller between the MEM pipeline stage and a single-ported, handshaked data-memory bus. Accepts one load/store per transaction and checks alignment before any bus cycle. Drives word-aligned bus requests with byte enables and lane-shifted write data, then returns lane-extracted, sign/zero-extended load data. Stalls the pipeline via `req_ready` and raises a one-cycle exception on misalignment or bus timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles `bus_req` may stay high without `bus_ack` before a timeout. 0 disables the timeout.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: pipeline presents an access.
- `req_write` in 1: 1 = store, 0 = load.
- `req_width` in 2: access width, encoded with the shared `memWidth1/2/4` constants.
- `req_signext` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_ready` out 1: controller can accept; equals `state == IDLE`.
- `resp_valid` out 1: one-cycle completion pulse, for loads and stores.
- `resp_rdata` out 32: extracted load data; 0 for stores.
- `exception` out 1: one-cycle pulse.
- `exc_cause` out 2: 0 none, 1 load misaligned, 2 store misaligned, 3 bus timeout.
- `exc_addr` out 32: byte address of the faulting access.
- `bus_req` out 1: bus cycle request, held until ack or timeout.
- `bus_we` out 1: write strobe.
- `bus_addr` out 32: `{req_addr[31:2], 2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-shifted store data.
- `bus_ack` in 1: bus completion; `bus_rdata` is valid in the same cycle.
- `bus_rdata` in 32: read word.

## Operation
- States are IDLE and BUS. Acceptance happens when `req_valid && req_ready`. Address, width, write and signext are captured in registers.
- Misalignment rules:
  - Word access requires `addr[1:0]==0`.
  - Half access requires `addr[0]==0`.
  - Byte access is never misaligned.
- On a misaligned accept:
  - No bus cycle is issued and the state stays IDLE.
  - Next cycle: `exception=1`, cause 1 or 2, `exc_addr=req_addr`, `resp_valid=0`.
- On an aligned accept, go to BUS with `bus_req=1`. Outputs are registered.
- Byte enables:
  - Word: 1111.
  - Half: 1100 if `addr[1]`, else 0011.
  - Byte: `4'b0001 << addr[1:0]`.
- `bus_wdata` places the low 16/8 bits of `req_wdata` in the enabled lane. All other bits are 0. For loads, `bus_wdata=0` and `bus_we=0`.
- On `bus_ack` in BUS:
  - Drop `bus_req` and return to IDLE.
  - Pulse `resp_valid`.
  - Loads: `resp_rdata` = selected lane (half lane per `addr[1]`, byte lane per `addr[1:0]`), extended to 32 bits per captured signext. Word loads pass through unchanged.
- Timeout: a counter clears on entry to BUS and increments each BUS cycle without ack. When it reaches `TIMEOUT_CYCLES`:
  - Drop `bus_req` and return to IDLE.
  - Pulse `exception` with cause 3. No `resp_valid`.
- Ack and timeout in the same cycle: the ack wins.
- `bus_ack` while not in BUS is ignored.
- Reset: state IDLE, counter 0, every output 0 except `req_ready=1`. Reset during BUS aborts the transaction: `bus_req` is low on the next cycle and no response or exception is produced.

## Timing
- Cycle 0: accept. Cycle 1: `bus_req` high with all bus fields stable.
- Ack in cycle k≥1 → `resp_valid` and data registered, visible in cycle k+1. `req_ready=1` in cycle k+1, so a new accept is possible in k+1.
- Minimum load/store latency is 2 cycles. Maximum throughput is one access per 2 cycles.
- Misaligned: exception visible in cycle 1. `req_ready` stays high, so back-to-back accepts are allowed.
- Timeout: with `bus_req` first high in cycle 1, the exception is visible in cycle `TIMEOUT_CYCLES+1` and `bus_req` is low in that same cycle.
- Bus fields must not change while `bus_req` is high.

## Structure
- `memWidth*` encodings and `exc_cause` codes (`EXC_NONE`, `EXC_ADEL`, `EXC_ADES`, `EXC_BUSTO`) live in the shared constants package.
- The state enum is local.
- One combinational sub-module, `dm_lane_extract`, handles load lane selection and extension: inputs `rdata`, `addr[1:0]`, `width`, `signext`.

## Test plan
- Word store to 0x100, data 0xDEADBEEF, ack in cycle 1 → `bus_be=1111`, `bus_wdata=0xDEADBEEF`, `bus_addr=0x100`, `resp_valid` in cycle 2.
- Byte load from 0x103 with signext=1, `bus_rdata=0x80FF_0000`, ack after 3 wait cycles → `bus_be=1000`, `resp_rdata=0xFFFFFF80`. Repeat with signext=0 → `0x00000080`.
- Half store to 0x202, data 0x1234ABCD → `bus_be=1100`, `bus_wdata=0xABCD0000`, `bus_addr=0x200`.
- Word load from 0x301 → no `bus_req`, `exception` in cycle 1, cause 1, `exc_addr=0x301`. Half store to 0x305 → cause 2.
- `TIMEOUT_CYCLES=4`, no ack → `bus_req` high cycles 1–4, cause 3 in cycle 5. A late ack in cycle 6 is ignored. Ack exactly in cycle 4 → response, no exception.
- `reset` asserted in cycle 2 of a pending load → `bus_req=0` in cycle 3, no `resp_valid` or `exception`, `req_ready=1`.

Source files
------------

// File: rtl/dm_access_ctrl_pkg.sv
// Shared memory-access constants and lane helpers for the data-memory
// access controller.
package dm_access_ctrl_pkg;

    localparam logic [1:0] memWidth1 = 2'd0;
    localparam logic [1:0] memWidth2 = 2'd1;
    localparam logic [1:0] memWidth4 = 2'd2;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_ADEL  = 2'd1;
    localparam logic [1:0] EXC_ADES  = 2'd2;
    localparam logic [1:0] EXC_BUSTO = 2'd3;

    function automatic logic misaligned(
        input logic [1:0] w,
        input logic [1:0] a
    );
        logic m;
        unique case (1'b1)
            w == memWidth1: m = 1'b0;
            w == memWidth2: m = a[0];
            default:        m = |a;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] byte_en(
        input logic [1:0] w,
        input logic [1:0] a
    );
        logic [3:0] be;
        unique case (1'b1)
            w == memWidth1: be = 4'b0001 << a;
            w == memWidth2: be = a[1] ? 4'b1100 : 4'b0011;
            default:        be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(
        input logic [1:0]  w,
        input logic [1:0]  a,
        input logic [31:0] d
    );
        logic [31:0] o;
        unique case (1'b1)
            w == memWidth1: o = {24'd0, d[7:0]} << {a, 3'b000};
            w == memWidth2: o = a[1] ? {d[15:0], 16'd0}
                                     : {16'd0, d[15:0]};
            default:        o = d;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dm_lane_extract.sv
// Picks the addressed byte/half lane out of a bus read word and
// sign- or zero-extends it to 32 bits.
module dm_lane_extract
    import dm_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  width,
    input  logic        signext,
    output logic [31:0] data
);

    logic [15:0] half;
    logic [7:0]  byt;

    assign half = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        byt = rdata[7:0];
        unique case (addr)
            2'd0: byt = rdata[7:0];
            2'd1: byt = rdata[15:8];
            2'd2: byt = rdata[23:16];
            2'd3: byt = rdata[31:24];
        endcase
    end

    always_comb begin
        data = rdata;
        unique case (1'b1)
            width == memWidth1:
                data = {{24{signext & byt[7]}}, byt};
            width == memWidth2:
                data = {{16{signext & half[15]}}, half};
            default:
                data = rdata;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage sequencer for a single-ported handshaked data-memory bus:
// alignment check, lane steering, load extraction and bus timeout.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic        req_signext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        exception,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic {IDLE, BUS} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TEN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] TLAST =
        CW'(TEN ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q;
    logic [1:0]    width_q;
    logic          write_q;
    logic          signext_q;
    logic [3:0]    be_q;
    logic [31:0]   wd_q;
    logic [31:0]   ext;

    logic        accept, mis, ack, tmo, fault;
    logic        resp_valid_n, exception_n;
    logic [31:0] resp_rdata_n, exc_addr_n;
    logic [1:0]  exc_cause_n;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign mis       = misaligned(req_width, req_addr[1:0]);
    assign fault     = accept & mis;
    assign ack       = (state == BUS) & bus_ack;
    // ack takes priority over an expiring counter in the same cycle
    assign tmo       = TEN & (state == BUS) & ~bus_ack & (cnt == TLAST);

    dm_lane_extract u_extract (
        .rdata   (bus_rdata),
        .addr    (addr_q[1:0]),
        .width   (width_q),
        .signext (signext_q),
        .data    (ext)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept && !mis)     state_n = BUS;
            BUS:  if (bus_ack || tmo)     state_n = IDLE;
        endcase
    end

    always_comb begin
        resp_valid_n = ack;
        resp_rdata_n = (ack && !write_q) ? ext : 32'd0;
        exception_n  = fault | tmo;
        exc_cause_n  = EXC_NONE;
        exc_addr_n   = 32'd0;
        if (fault) begin
            exc_cause_n = req_write ? EXC_ADES : EXC_ADEL;
            exc_addr_n  = req_addr;
        end else if (tmo) begin
            exc_cause_n = EXC_BUSTO;
            exc_addr_n  = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            addr_q     <= 32'd0;
            width_q    <= memWidth1;
            write_q    <= 1'b0;
            signext_q  <= 1'b0;
            be_q       <= 4'd0;
            wd_q       <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            exception  <= 1'b0;
            exc_cause  <= EXC_NONE;
            exc_addr   <= 32'd0;
        end else begin
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            exception  <= exception_n;
            exc_cause  <= exc_cause_n;
            exc_addr   <= exc_addr_n;
            if (TEN && state == BUS) cnt <= cnt + 1'b1;
            else                     cnt <= '0;
            if (accept && !mis) begin
                addr_q    <= req_addr;
                width_q   <= req_width;
                write_q   <= req_write;
                signext_q <= req_signext;
                be_q      <= byte_en(req_width, req_addr[1:0]);
                wd_q      <= req_write
                           ? lane_wdata(req_width, req_addr[1:0], req_wdata)
                           : 32'd0;
            end
        end
    end

    // bus fields are held from captured registers, quiet outside BUS
    assign bus_req   = (state == BUS);
    assign bus_we    = bus_req & write_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_be    = bus_req ? be_q : 4'd0;
    assign bus_wdata = bus_req ? wd_q : 32'd0;

endmodule
